// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debounce_pkg
// Description : Shared types and constants for the scheduled multi-channel
//               button debouncer: channel FSM states, detection-mode
//               encodings, the saturating tick counter type and the
//               per-channel context record kept by the debounce engine.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package debounce_pkg;

   // Channel FSM. ZERO/ONE are the settled debounced levels; HOLD1/HOLD0 are
   // the early-detection lockout windows after a rising/falling edge.
   typedef enum logic [1:0] {
      ZERO  = 2'd0,
      ONE   = 2'd1,
      HOLD1 = 2'd2,
      HOLD0 = 2'd3
   } ch_state_e;

   localparam logic MODE_LATE  = 1'b0;
   localparam logic MODE_EARLY = 1'b1;

   // Stability / lockout counter, measured in sample ticks.
   typedef logic [7:0] cnt_t;

   typedef struct packed {
      ch_state_e state;
      cnt_t      cnt;
   } ch_ctx_t;

   localparam ch_ctx_t CTX_RESET = '{state: ZERO, cnt: 8'd0};

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/debounce_scheduler_sync.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchronizer bank for asynchronous level inputs.
// Ports       : clk   - destination clock
//               rst_n - asynchronous active-low reset (clears both stages)
//               d     - asynchronous input levels [WIDTH]
//               q     - synchronized levels [WIDTH]
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule : sync_2ff
`default_nettype wire

// File: rtl/debounce_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : debounce_scheduler
// Description : Multi-channel button debouncer built from one shared sample
//               tick generator and one time-multiplexed debounce engine.
//               Every tick starts a sweep that services one channel per
//               clock (channel k in the k+1-th cycle after the tick). Each
//               channel runs late detection (edge reported after
//               STABLE_TICKS stable samples) or early detection (edge
//               reported at once, then a STABLE_TICKS lockout).
//               Optional feature macro: DEBOUNCE_LONG_PRESS_EN adds
//               long_press_o, a one-shot pulse after LONG_TICKS services
//               held pressed.
// Ports       : clk_i        - system clock
//               rst_ni       - asynchronous active-low reset, released
//                              synchronously to clk_i by the reset source
//               btn_i        - raw asynchronous button levels [N_CH]
//               mode_i       - per-channel mode, 0 late / 1 early [N_CH]
//               debounced_o  - debounced levels [N_CH]
//               press_o      - 1-cycle pulse on debounced rise [N_CH]
//               release_o    - 1-cycle pulse on debounced fall [N_CH]
//               long_press_o - 1-cycle long-press pulse [N_CH]
//                              (DEBOUNCE_LONG_PRESS_EN only)
//               tick_o       - 1-cycle pulse when a sample tick fires
//               busy_o       - high while a service sweep is running
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_scheduler
   import debounce_pkg::*;
#(
   parameter int N_CH         = 4,
   parameter int TICK_CYCLES  = 1000,
   parameter int STABLE_TICKS = 8,
   parameter int LONG_TICKS   = 256
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic [N_CH-1:0] btn_i,
   input  logic [N_CH-1:0] mode_i,
   output logic [N_CH-1:0] debounced_o,
   output logic [N_CH-1:0] press_o,
   output logic [N_CH-1:0] release_o,
`ifdef DEBOUNCE_LONG_PRESS_EN
   output logic [N_CH-1:0] long_press_o,
`endif
   output logic            tick_o,
   output logic            busy_o
);

   localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam int IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1;

   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_CH - 1);
   localparam cnt_t              STABLE    = cnt_t'(STABLE_TICKS);

   // ------------------------------------------------------------------
   // Elaboration-time parameter range checks
   // ------------------------------------------------------------------
   if (N_CH < 1 || N_CH > 16) begin : g_bad_n_ch
      $error("debounce_scheduler: N_CH out of range 1..16");
   end
   if (TICK_CYCLES < N_CH + 2) begin : g_bad_tick
      $error("debounce_scheduler: TICK_CYCLES must be >= N_CH+2");
   end
   if (STABLE_TICKS < 1 || STABLE_TICKS > 255) begin : g_bad_stable
      $error("debounce_scheduler: STABLE_TICKS out of range 1..255");
   end
   if (LONG_TICKS < 1 || LONG_TICKS > 511) begin : g_bad_long
      $error("debounce_scheduler: LONG_TICKS out of range 1..511");
   end

   // ------------------------------------------------------------------
   // Input synchronization
   // ------------------------------------------------------------------
   logic [N_CH-1:0] btn_sync;

   sync_2ff #(
      .WIDTH (N_CH)
   ) u_sync (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .d     (btn_i),
      .q     (btn_sync)
   );

   // ------------------------------------------------------------------
   // Sample tick generator
   // ------------------------------------------------------------------
   logic [TICK_W-1:0] tick_cnt;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tick_cnt <= '0;
      end else if (tick_cnt == TICK_LAST) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + TICK_W'(1);
      end
   end

   // Decoded straight from the counter register, so it is glitch-free and
   // lines up with the cycle the counter holds its terminal value.
   assign tick_o = (tick_cnt == TICK_LAST);

   // ------------------------------------------------------------------
   // Sweep sequencer: busy_o marks the service window, idx the channel
   // being serviced in the current cycle.
   // ------------------------------------------------------------------
   logic [IDX_W-1:0] idx;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_o <= 1'b0;
         idx    <= '0;
      end else if (tick_o) begin
         busy_o <= 1'b1;
         idx    <= '0;
      end else if (busy_o) begin
         if (idx == IDX_LAST) begin
            busy_o <= 1'b0;
            idx    <= '0;
         end else begin
            idx <= idx + IDX_W'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Channel service function
   // ------------------------------------------------------------------
   typedef struct packed {
      ch_ctx_t ctx;
      logic    mode;
      logic    deb;
      logic    press;
      logic    rel;
   } svc_t;

   function automatic svc_t service(
      input ch_ctx_t ctx,
      input logic    mode_seen,
      input logic    mode,
      input logic    s,
      input logic    deb
   );
      svc_t r;
      cnt_t cnt_inc;
      logic toward;

      r.ctx   = ctx;
      r.mode  = mode_seen;
      r.deb   = deb;
      r.press = 1'b0;
      r.rel   = 1'b0;

      // Saturating increment; the counter never needs to exceed STABLE.
      cnt_inc = (ctx.cnt < STABLE) ? ctx.cnt + cnt_t'(1) : STABLE;
      // Sample pushes toward the opposite level of the settled state.
      toward  = (ctx.state == ZERO) ? s : ~s;

      case (ctx.state)
         ZERO, ONE: begin
            r.mode = mode;
            if (mode != mode_seen) begin
               // Switching detection style restarts any partial count.
               r.ctx.cnt = '0;
            end else if (!toward) begin
               r.ctx.cnt = '0;
            end else if (mode == MODE_EARLY || cnt_inc == STABLE) begin
               r.ctx.cnt = '0;
               if (ctx.state == ZERO) begin
                  r.deb       = 1'b1;
                  r.press     = 1'b1;
                  r.ctx.state = (mode == MODE_EARLY) ? HOLD1 : ONE;
               end else begin
                  r.deb       = 1'b0;
                  r.rel       = 1'b1;
                  r.ctx.state = (mode == MODE_EARLY) ? HOLD0 : ZERO;
               end
            end else begin
               r.ctx.cnt = cnt_inc;
            end
         end
         HOLD1, HOLD0: begin
            // Lockout: the input and mode are ignored until the window ends.
            if (cnt_inc == STABLE) begin
               r.ctx.cnt   = '0;
               r.ctx.state = (ctx.state == HOLD1) ? ONE : ZERO;
            end else begin
               r.ctx.cnt = cnt_inc;
            end
         end
         default: begin
            r.ctx = CTX_RESET;
         end
      endcase
      return r;
   endfunction

   // ------------------------------------------------------------------
   // Per-channel context and registered outputs
   // ------------------------------------------------------------------
   ch_ctx_t         ctx_q [N_CH];
   logic [N_CH-1:0] mode_q;     // mode seen at the last ZERO/ONE service
   svc_t            svc;

   always_comb begin
      svc = service(ctx_q[idx], mode_q[idx], mode_i[idx], btn_sync[idx],
                    debounced_o[idx]);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int k = 0; k < N_CH; k++) begin
            ctx_q[k] <= CTX_RESET;
         end
         mode_q      <= '0;
         debounced_o <= '0;
         press_o     <= '0;
         release_o   <= '0;
      end else begin
         press_o   <= '0;
         release_o <= '0;
         if (busy_o) begin
            ctx_q[idx]       <= svc.ctx;
            mode_q[idx]      <= svc.mode;
            debounced_o[idx] <= svc.deb;
            press_o[idx]     <= svc.press;
            release_o[idx]   <= svc.rel;
         end
      end
   end

`ifdef DEBOUNCE_LONG_PRESS_EN
   // ------------------------------------------------------------------
   // Long-press detection: counts services spent pressed, fires once when
   // the count reaches LONG_TICKS and then parks there until the release.
   // ------------------------------------------------------------------
   localparam logic [8:0] LONG = 9'(LONG_TICKS);

   logic [8:0] hold_cnt [N_CH];
   logic [8:0] hold_inc;

   assign hold_inc = hold_cnt[idx] + 9'd1;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int k = 0; k < N_CH; k++) begin
            hold_cnt[k] <= '0;
         end
         long_press_o <= '0;
      end else begin
         long_press_o <= '0;
         if (busy_o) begin
            if (svc.press) begin
               hold_cnt[idx] <= '0;
            end else if (debounced_o[idx] && !svc.rel && hold_cnt[idx] < LONG) begin
               hold_cnt[idx] <= hold_inc;
               if (hold_inc == LONG) begin
                  long_press_o[idx] <= 1'b1;
               end
            end
         end
      end
   end
`endif

endmodule : debounce_scheduler
`default_nettype wire

// File: tb/tb_debounce_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_debounce_scheduler
// Description : Scoreboard bench for debounce_scheduler (N_CH=4,
//               TICK_CYCLES=8, STABLE_TICKS=4, LONG_TICKS=16). Stimulus
//               changes are applied at cycle 8*j+2 so they are first sampled
//               by tick j, whose channel-k result becomes visible in cycle
//               8*j+9+k. Expected pulse events are queued at stimulus time
//               and checked by an independent monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debounce_scheduler;

   logic       clk;
   logic       rst_ni;
   logic [3:0] btn_i;
   logic [3:0] mode_i;
   logic [3:0] debounced_o;
   logic [3:0] press_o;
   logic [3:0] release_o;
   logic       tick_o;
   logic       busy_o;
   logic [3:0] lp_w;

`ifdef DEBOUNCE_LONG_PRESS_EN
   logic [3:0] long_press_o;
   assign lp_w = long_press_o;
`else
   assign lp_w = 4'h0;
`endif

   debounce_scheduler #(
      .N_CH         (4),
      .TICK_CYCLES  (8),
      .STABLE_TICKS (4),
      .LONG_TICKS   (16)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .btn_i        (btn_i),
      .mode_i       (mode_i),
      .debounced_o  (debounced_o),
      .press_o      (press_o),
      .release_o    (release_o),
`ifdef DEBOUNCE_LONG_PRESS_EN
      .long_press_o (long_press_o),
`endif
      .tick_o       (tick_o),
      .busy_o       (busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle index since the last reset release (= DUT tick counter phase).
   int cyc;
   always @(posedge clk) begin
      if (!rst_ni) cyc <= 0;
      else         cyc <= cyc + 1;
   end

   typedef struct {
      int         c;
      logic [3:0] press;
      logic [3:0] rel;
      logic [3:0] lp;
      logic [3:0] deb;
   } ev_t;

   ev_t exp_q[$];
   int  n_cmp = 0;
   int  n_bad = 0;

   task automatic chk(input string nm, input int act, input int expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cyc %0d",
                  nm, act, act, expv, expv, cyc);
      end
   endtask

   task automatic push(input int c, input logic [3:0] p, input logic [3:0] r,
                       input logic [3:0] l, input logic [3:0] d);
      ev_t e;
      e.c = c; e.press = p; e.rel = r; e.lp = l; e.deb = d;
      exp_q.push_back(e);
   endtask

   task automatic wait_cycle(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // Value applied here is first sampled by tick j.
   task automatic set_btn(input int j, input logic [3:0] v);
      wait_cycle(8 * j + 2);
      btn_i = v;
   endtask

   // ------------------------------------------------------------------
   // Monitor: any pulse on the outputs must match the next queued event.
   // ------------------------------------------------------------------
   always @(negedge clk) begin
      if (rst_ni && ((press_o | release_o | lp_w) != 4'h0)) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_event: press=%b release=%b long=%b at cyc %0d, expected none",
                     press_o, release_o, lp_w, cyc);
         end else begin
            ev_t e;
            e = exp_q.pop_front();
            chk("event_cycle",   cyc,                e.c);
            chk("event_press",   int'(press_o),      int'(e.press));
            chk("event_release", int'(release_o),    int'(e.rel));
            chk("event_long",    int'(lp_w),         int'(e.lp));
            chk("event_deb",     int'(debounced_o),  int'(e.deb));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int first_tick;
      int first_busy;
      int busy_cycles;

      rst_ni = 1'b0;
      btn_i  = 4'hF;
      mode_i = 4'b0010;          // ch1 early, others late
      repeat (3) @(negedge clk);
      chk("rst_debounced", int'(debounced_o), 0);
      chk("rst_pulses",    int'(press_o | release_o | lp_w), 0);
      chk("rst_tick",      int'(tick_o), 0);
      chk("rst_busy",      int'(busy_o), 0);

      btn_i  = 4'h0;
      rst_ni = 1'b1;

      first_tick  = -1;
      first_busy  = -1;
      busy_cycles = 0;
      for (int i = 0; i < 16; i++) begin
         if (tick_o && first_tick < 0) first_tick = cyc;
         if (busy_o) begin
            busy_cycles++;
            if (first_busy < 0) first_busy = cyc;
         end
         @(negedge clk);
      end
      chk("first_tick_cycle", first_tick, 7);
      chk("first_busy_cycle", first_busy, 8);
      chk("busy_length",      busy_cycles, 4);

      // ch0 late, held: ticks 2..5 -> press at tick 5, ch0
      set_btn(2, 4'b0001);
      push(49, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
      // ch3 late with bounce: 1,1,0 then 1 from tick 6 -> press at tick 9
      set_btn(3, 4'b1001);
      set_btn(5, 4'b0001);
      set_btn(6, 4'b1001);
      push(84, 4'b1000, 4'b0000, 4'b0000, 4'b1001);
      // ch1 early: 1 at tick 10, 0 for ticks 11-12, 1 again -> single press
      set_btn(10, 4'b1011);
      push(90, 4'b0010, 4'b0000, 4'b0000, 4'b1011);
      set_btn(11, 4'b1001);
      set_btn(13, 4'b1011);
      // all released at tick 16: ch1 early at once, ch0/ch3 late at tick 19
      set_btn(16, 4'b0000);
      push(138, 4'b0000, 4'b0010, 4'b0000, 4'b1001);
      push(161, 4'b0000, 4'b0001, 4'b0000, 4'b1000);
      push(164, 4'b0000, 4'b1000, 4'b0000, 4'b0000);
      // ch0 late + ch1 early pressed together at tick 22
      set_btn(22, 4'b0011);
      push(186, 4'b0000 | 4'b0010, 4'b0000, 4'b0000, 4'b0010);
      push(209, 4'b0001, 4'b0000, 4'b0000, 4'b0011);

      // async reset in the middle of the tick-27 sweep (cycles 224..227)
      wait_cycle(225);
      chk("pre_reset_deb",  int'(debounced_o), 3);
      chk("pre_reset_busy", int'(busy_o), 1);
      #2;
      rst_ni = 1'b0;
      btn_i  = 4'h0;
      #1;
      chk("midreset_debounced", int'(debounced_o), 0);
      chk("midreset_busy",      int'(busy_o), 0);
      chk("midreset_pulses",    int'(press_o | release_o | lp_w), 0);
      chk("queue_drained_1",    exp_q.size(), 0);
      repeat (2) @(negedge clk);
      rst_ni = 1'b1;

      wait_cycle(17);
      chk("post_reset_quiet", int'(debounced_o), 0);

      // ch2 late held for ~43 ticks
      set_btn(2, 4'b0100);
      push(51, 4'b0100, 4'b0000, 4'b0000, 4'b0100);
`ifdef DEBOUNCE_LONG_PRESS_EN
      push(179, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
`endif
      set_btn(45, 4'b0000);
      push(395, 4'b0000, 4'b0100, 4'b0000, 4'b0000);

      wait_cycle(410);
      chk("queue_drained_2", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_debounce_scheduler
`default_nettype wire

// File: doc/debounce_scheduler.md
Name: debounce_scheduler

Overview:
- Multi-channel button debounce controller; one shared sample-tick generator and one time-multiplexed debounce engine serve N_CH raw button inputs.
- Per channel, selectable late detection (output changes only after input is stable) or early detection (output changes on first new sample, then input is ignored for a lockout window).
- Sits between raw pad inputs and user logic; replaces per-button debouncer instances with one scheduled resource.

Parameters:
- N_CH, 4, number of button channels (1..16).
- TICK_CYCLES, 1000, clocks per sample tick; must be >= N_CH+2.
- STABLE_TICKS, 8, ticks of stability (late) or lockout (early); 1..255.
- LONG_TICKS, 256, ticks pressed before long-press event (optional feature only).

Ports:
- clk_i  in  1  system clock
- rst_ni  in  1  asynchronous active-low reset
- btn_i  in  N_CH  raw asynchronous button levels
- mode_i  in  N_CH  per-channel mode: 0 = late detection, 1 = early detection
- debounced_o  out  N_CH  debounced levels
- press_o  out  N_CH  1-cycle pulse on debounced 0->1
- release_o  out  N_CH  1-cycle pulse on debounced 1->0
- tick_o  out  1  1-cycle pulse when a sample tick fires (observability)
- busy_o  out  1  high while a service sweep is in progress

Behaviour:
- Reset (async assert, sync release): all outputs 0, tick counter 0, sweep idle, all channels state ZERO, cnt 0, synchronizer flops 0.
- Each btn_i bit passes through a 2-flop synchronizer; only synchronized values are sampled.
- Tick counter counts 0..TICK_CYCLES-1 and wraps; tick_o = 1 in the cycle the counter equals TICK_CYCLES-1.
- Sweep: the cycle after tick_o, busy_o rises; channel k is serviced in cycle k+1 after tick (k = 0..N_CH-1), one channel per cycle; busy_o drops after channel N_CH-1. A sweep always finishes before the next tick.
- Service of channel k reads its synchronized bit s and mode_i[k], and updates state, cnt, debounced_o[k]. debounced_o[k] changes at the end of the service cycle; press_o/release_o pulse in the same registered update and stay high exactly 1 cycle.
- Channel FSM states: ZERO, ONE, HOLD1, HOLD0. cnt is 8 bits and saturates at STABLE_TICKS.
- Late mode, ZERO: s=1 increments cnt, s=0 clears cnt. When the increment makes cnt == STABLE_TICKS: debounced=1, press pulse, go to ONE, cnt=0. ONE mirrors this with s=0, release pulse, and a return to ZERO.
- Early mode, ZERO: s=1 sets debounced=1, press pulse, goes to HOLD1, cnt=0. ONE: s=0 sets debounced=0, release pulse, goes to HOLD0.
- HOLD1/HOLD0 ignore s and mode; cnt increments each service; at cnt == STABLE_TICKS go to ONE/ZERO and clear cnt. HOLD states are entered only in early mode.
- A mode change seen in ZERO/ONE clears cnt in that service; no output change. Pulses on different channels never coincide because channels are serviced in different cycles.
- Reset mid-sweep aborts the sweep; all state returns to reset values immediately.

Optional Feature:
- Macro DEBOUNCE_LONG_PRESS_EN.
- Defined: adds output long_press_o [N_CH] and a per-channel 9-bit press-duration counter. The counter clears on press and increments each service while debounced=1. long_press_o[k] pulses 1 cycle in the service where the count reaches LONG_TICKS, once per press; the counter then holds until release.
- Undefined: the port, counters and logic are absent; all other behaviour is identical.

Decomposition:
- Package debounce_pkg: ch_state_e enum (ZERO, ONE, HOLD1, HOLD0), MODE_LATE/MODE_EARLY constants, cnt_t typedef (8-bit), ch_ctx_t struct {state, cnt} used for the per-channel context array.
- One sub-module: sync_2ff (parameterized width, async active-low reset), instantiated once at width N_CH. The FSM update stays in a function inside debounce_scheduler.

Test Plan (N_CH=4, TICK_CYCLES=8, STABLE_TICKS=4):
- Reset: hold rst_ni=0 with btn_i=4'hF -> all outputs 0; after release, first tick_o at cycle 7 and busy_o high for exactly 4 cycles.
- Late, ch0: btn_i[0]=1 held -> debounced_o[0] rises in the service of the 4th tick sampling 1, with one press_o[0] pulse. With a bounce (1 for 2 ticks, 0 for 1 tick, 1) -> rise delayed until 4 consecutive 1 samples.
- Early, ch1 (mode_i[1]=1): btn_i[1] 1 for 1 tick, 0 for 2 ticks, 1 -> debounced_o[1] rises at the first 1 sample and stays 1 through lockout; single press_o[1].
- Release in both modes: drop ch0/ch1 to 0 -> release_o pulses once each, in service cycles 1 and 2 after the tick; never in the same cycle.
- Async reset asserted in the middle of a sweep with debounced_o=4'h3 -> outputs 0 immediately, no pulses after reset release until new stable input.
- DEBOUNCE_LONG_PRESS_EN with LONG_TICKS=16: hold ch2 pressed 40 ticks -> exactly one long_press_o[2] pulse, 16 services after press.
